// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory port arbiter.
package mem_port_arbiter_pkg;

  // Requester identifiers recorded in the outstanding-ID FIFO.
  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  // Access size encodings carried on the size fields.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Arbiter states: free to pick a requester, or holding a granted address phase.
  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// SRAM-like request/response bus used by both requesters and the downstream port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  // Issues requests and consumes handshakes/responses.
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Accepts requests and produces handshakes/responses.
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_port_arbiter_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-unanswered requests.
module id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] slots_q, slots_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = slots_q[rd_ptr_q];

  // A full FIFO still takes a push in the cycle it pops: the freed slot is the one written.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Next pointer, count and storage values.
  always_comb begin
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slots_d[wr_ptr_q] = din_i;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slots_q  <= slots_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch (port 0) and data (port 1),
// holding each grant until its address is accepted and routing responses in order.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.slave   inst_if,
  mem_port_arbiter_if.slave   data_if,
  mem_port_arbiter_if.master  mem_if
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              sel;
  logic              req_live;
  logic              mem_req;
  logic              push, pop;
  logic              fifo_full, fifo_empty, head_id;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // Grant selection and next state; the full check uses the registered count only.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel      = grant_q;
    req_live = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (!fifo_full) begin
          if (data_if.req) begin
            sel      = PORT_DATA;
            req_live = 1'b1;
          end else if (inst_if.req) begin
            sel      = PORT_INST;
            req_live = 1'b1;
          end
          if (req_live && !mem_if.addr_ok) begin
            state_d = ARB_LOCK;
            grant_d = sel;
          end
        end
      end
      ARB_LOCK: begin
        sel      = grant_q;
        req_live = 1'b1;
        if (mem_if.addr_ok) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state and latched grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= PORT_INST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Request is forced low while reset is asserted so nothing leaks downstream.
  assign mem_req = req_live && resetn;
  assign push    = mem_req && mem_if.addr_ok;
  assign pop     = mem_if.data_ok && !fifo_empty && resetn;

  assign addr_mux  = (sel == PORT_DATA) ? data_if.addr  : inst_if.addr;
  assign wdata_mux = (sel == PORT_DATA) ? data_if.wdata : inst_if.wdata;

  assign mem_if.req   = mem_req;
  assign mem_if.wr    = (sel == PORT_DATA) ? data_if.wr    : inst_if.wr;
  assign mem_if.size  = (sel == PORT_DATA) ? data_if.size  : inst_if.size;
  assign mem_if.wstrb = (sel == PORT_DATA) ? data_if.wstrb : inst_if.wstrb;
  assign mem_if.addr  = addr_mux;
  assign mem_if.wdata = wdata_mux;

  assign inst_if.addr_ok = push && (sel == PORT_INST);
  assign data_if.addr_ok = push && (sel == PORT_DATA);

  assign inst_if.data_ok = pop && (head_id == PORT_INST);
  assign data_if.data_ok = pop && (head_id == PORT_DATA);
  assign inst_if.rdata   = mem_if.rdata;
  assign data_if.rdata   = mem_if.rdata;

  id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .din_i   (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_id)
  );

  // A response with no recorded requester is dropped; flag it in simulation.
  assert property (@(posedge clk) disable iff (!resetn) mem_if.data_ok |-> !fifo_empty)
    else $error("mem_port_arbiter: mem_data_ok with no outstanding request");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned MAXO = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_port_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .inst_if (inst_bus),
    .data_if (data_bus),
    .mem_if  (mem_bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: port whose address phase is pending (-1 none) and queue of outstanding ports.
  int pend_port = -1;
  int exp_q[$];
  bit inst_acc = 1'b0;
  bit data_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    int  g;
    bit  pop_e;
    if (!resetn) begin
      exp_q.delete();
      pend_port = -1;
      inst_acc  = 1'b0;
      data_acc  = 1'b0;
      chk("rst_mem_req", mem_bus.req, 1'b0);
      chk("rst_ok", {inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}, 4'b0);
    end else begin
      if (pend_port >= 0)                                     g = pend_port;
      else if (exp_q.size() < MAXO && data_bus.req)           g = 1;
      else if (exp_q.size() < MAXO && inst_bus.req)           g = 0;
      else                                                    g = -1;

      chk("mem_req", mem_bus.req, g >= 0);
      if (g == 1) begin
        chk("mem_addr_d",  mem_bus.addr,  data_bus.addr);
        chk("mem_wr_d",    mem_bus.wr,    data_bus.wr);
        chk("mem_size_d",  mem_bus.size,  data_bus.size);
        chk("mem_wstrb_d", mem_bus.wstrb, data_bus.wstrb);
        chk("mem_wdata_d", mem_bus.wdata, data_bus.wdata);
      end else if (g == 0) begin
        chk("mem_addr_i",  mem_bus.addr,  inst_bus.addr);
        chk("mem_wr_i",    mem_bus.wr,    inst_bus.wr);
        chk("mem_size_i",  mem_bus.size,  inst_bus.size);
        chk("mem_wstrb_i", mem_bus.wstrb, inst_bus.wstrb);
        chk("mem_wdata_i", mem_bus.wdata, inst_bus.wdata);
      end
      inst_acc = (g == 0) && mem_bus.addr_ok;
      data_acc = (g == 1) && mem_bus.addr_ok;
      chk("inst_addr_ok", inst_bus.addr_ok, inst_acc);
      chk("data_addr_ok", data_bus.addr_ok, data_acc);

      pop_e = mem_bus.data_ok && (exp_q.size() > 0);
      chk("inst_data_ok", inst_bus.data_ok, pop_e && exp_q[0] == 0);
      chk("data_data_ok", data_bus.data_ok, pop_e && exp_q[0] == 1);
      if (pop_e) begin
        chk("inst_rdata", inst_bus.rdata, mem_bus.rdata);
        chk("data_rdata", data_bus.rdata, mem_bus.rdata);
        void'(exp_q.pop_front());
      end

      if (g >= 0 && mem_bus.addr_ok) begin
        exp_q.push_back(g);
        pend_port = -1;
      end else if (g >= 0) begin
        pend_port = g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    inst_bus.req = req; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
    inst_bus.addr = addr; inst_bus.wstrb = 4'hf; inst_bus.wdata = 32'h0;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    data_bus.req = req; data_bus.wr = wr; data_bus.size = size;
    data_bus.addr = addr; data_bus.wstrb = wstrb; data_bus.wdata = wdata;
  endtask

  task automatic set_mem(input logic aok, input logic dok, input logic [31:0] rdata);
    mem_bus.addr_ok = aok; mem_bus.data_ok = dok; mem_bus.rdata = rdata;
  endtask

  initial begin
    set_inst(1'b1, 32'h1c000000);
    set_data(1'b1, 1'b0, 2'd2, 32'h1000, 4'hf, 32'h0);
    set_mem(1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    chk("lit_rst_req", mem_bus.req, 1'b0);
    chk("lit_rst_aok", {inst_bus.addr_ok, data_bus.addr_ok}, 2'b00);
    set_inst(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 2'd2, 32'h0, 4'hf, 32'h0);
    set_mem(1'b0, 1'b0, 32'h0);
    tick();
    resetn = 1'b1;

    // Simultaneous requests: data wins, inst follows; responses routed by order.
    tick();
    set_inst(1'b1, 32'h1c000000);
    set_data(1'b1, 1'b0, 2'd2, 32'h00001000, 4'hf, 32'h0);
    set_mem(1'b1, 1'b0, 32'h0);
    #3;
    chk("litA_daok", data_bus.addr_ok, 1'b1);
    chk("litA_iaok", inst_bus.addr_ok, 1'b0);
    chk("litA_addr", mem_bus.addr, 32'h00001000);
    tick();
    data_bus.req = 1'b0;
    #3;
    chk("litA_iaok2", inst_bus.addr_ok, 1'b1);
    chk("litA_addr2", mem_bus.addr, 32'h1c000000);
    tick();
    inst_bus.req = 1'b0;
    set_mem(1'b0, 1'b1, 32'hAAAA5555);
    #3;
    chk("litA_ddok", data_bus.data_ok, 1'b1);
    chk("litA_drd", data_bus.rdata, 32'hAAAA5555);
    tick();
    set_mem(1'b0, 1'b1, 32'h12345678);
    #3;
    chk("litA_idok", inst_bus.data_ok, 1'b1);
    chk("litA_ird", inst_bus.rdata, 32'h12345678);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);

    // Inst held in LOCK while data rises; then full FIFO stalls, pop frees a slot.
    tick();
    set_inst(1'b1, 32'h1c000000);
    #3;
    chk("litB_req", mem_bus.req, 1'b1);
    tick();
    set_data(1'b1, 1'b0, 2'd2, 32'h00001000, 4'hf, 32'h0);
    #3;
    chk("litB_lock_addr", mem_bus.addr, 32'h1c000000);
    chk("litB_lock_daok", data_bus.addr_ok, 1'b0);
    tick();
    tick();
    mem_bus.addr_ok = 1'b1;
    #3;
    chk("litB_iaok", inst_bus.addr_ok, 1'b1);
    chk("litB_addr", mem_bus.addr, 32'h1c000000);
    tick();
    inst_bus.req = 1'b0;
    #3;
    chk("litB_daok", data_bus.addr_ok, 1'b1);
    chk("litB_daddr", mem_bus.addr, 32'h00001000);
    tick();
    data_bus.addr = 32'h00002000;
    #3;
    chk("litB_full_req", mem_bus.req, 1'b0);
    tick();
    set_mem(1'b1, 1'b1, 32'hAAAA5555);
    #3;
    chk("litB_popcyc_req", mem_bus.req, 1'b0);
    chk("litB_idok", inst_bus.data_ok, 1'b1);
    tick();
    set_mem(1'b1, 1'b1, 32'h12345678);
    #3;
    chk("litB_resume_req", mem_bus.req, 1'b1);
    chk("litB_resume_daok", data_bus.addr_ok, 1'b1);
    chk("litB_ddok", data_bus.data_ok, 1'b1);
    tick();
    data_bus.req = 1'b0;
    set_mem(1'b0, 1'b1, 32'h00000055);
    #3;
    chk("litB_ddok2", data_bus.data_ok, 1'b1);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);

    // Byte write passes through unchanged and gets one response.
    tick();
    set_data(1'b1, 1'b1, 2'd0, 32'h00000003, 4'b1000, 32'hDEADBEEF);
    mem_bus.addr_ok = 1'b1;
    #3;
    chk("litC_wr", {mem_bus.wr, mem_bus.size, mem_bus.wstrb}, {1'b1, 2'd0, 4'b1000});
    chk("litC_addr", mem_bus.addr, 32'h00000003);
    tick();
    data_bus.req = 1'b0;
    set_mem(1'b0, 1'b1, 32'h0);
    #3;
    chk("litC_ddok", {inst_bus.data_ok, data_bus.data_ok}, 2'b01);
    tick();
    mem_bus.data_ok = 1'b0;
    #3;
    chk("litC_ddok_once", data_bus.data_ok, 1'b0);

    // Reset while one ID is outstanding and a data request is locked.
    tick();
    set_inst(1'b1, 32'h00000040);
    mem_bus.addr_ok = 1'b1;
    tick();
    inst_bus.req = 1'b0;
    set_data(1'b1, 1'b0, 2'd2, 32'h00000080, 4'hf, 32'h0);
    mem_bus.addr_ok = 1'b0;
    tick();
    resetn = 1'b0;
    set_mem(1'b1, 1'b1, 32'h0);
    #1;
    chk("litD_req", mem_bus.req, 1'b0);
    chk("litD_ok", {inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}, 4'b0);
    tick();
    data_bus.req = 1'b0;
    set_mem(1'b0, 1'b0, 32'h0);
    resetn = 1'b1;
    tick();
    set_data(1'b1, 1'b0, 2'd2, 32'h00000100, 4'hf, 32'h0);
    mem_bus.addr_ok = 1'b1;
    #3;
    chk("litD_new_daok", data_bus.addr_ok, 1'b1);
    tick();
    data_bus.req = 1'b0;
    set_mem(1'b0, 1'b1, 32'h00000077);
    #3;
    chk("litD_dok", {inst_bus.data_ok, data_bus.data_ok}, 2'b01);
    tick();
    set_mem(1'b0, 1'b0, 32'h0);

    // Randomized traffic obeying the requester and memory protocols.
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (inst_bus.req && inst_acc) inst_bus.req = 1'b0;
      if (data_bus.req && data_acc) data_bus.req = 1'b0;
      if (!inst_bus.req && $urandom_range(0, 2) == 0)
        set_inst(1'b1, $urandom & 32'hffff_fffc);
      if (!data_bus.req && $urandom_range(0, 2) == 0)
        set_data(1'b1, 1'($urandom), 2'($urandom_range(0, 2)), $urandom,
                 4'($urandom), $urandom);
      mem_bus.addr_ok = ($urandom_range(0, 2) != 0);
      mem_bus.data_ok = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_bus.rdata   = $urandom;
    end
    tick();
    set_inst(1'b0, 32'h0);
    data_bus.req = 1'b0;
    set_mem(1'b0, 1'b0, 32'h0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
